node_inj_queue: RTL and testbench
=================================

// Module: node_inj_queue
// PURPOSE
// - Local injection stage directly upstream of a MAZE mesh node's local input port (pkt_in side).
// - Takes packets from the local host and buffers them in two QoS classes.
// - Filters packets that target this node itself, or the power-gated node.
// - Arbitrates between classes with strict priority plus an anti-starvation limit.
// - Presents one packet at a time to the node on a registered valid/ready handshake.
// PARAMETERS
// - HP          3   X coordinate of the owning node (0..7)
// - VP          3   Y coordinate of the owning node (0..7)
// - DEPTH       4   entries per class FIFO; power of 2, >=2
// - STARVE_LIM  4   consecutive high-class grants allowed while low class waits (>=1)
// PORTS
// - clk          in   1  clock
// - rst          in   1  synchronous reset, active-high
// - pg_en        in   1  power-gating enable
// - pg_node      in   6  gated node id {x[2:0],y[2:0]}
// - host_vld     in   1  host packet valid
// - host_rdy     out  1  queue can accept the host packet (class selected by host_qos)
// - host_type    in   2  packet type
// - host_qos     in   1  1 = high class, 0 = low class
// - host_tgt     in   6  target node id {x,y}
// - host_data    in   8  payload
// - pkt_in_vld   out  1  packet valid toward node
// - pkt_in_rdy   in   1  node accepts packet
// - pkt_in_type  out  2  / pkt_in_qos out 1 / pkt_in_src out 6 / pkt_in_tgt out 6 / pkt_in_data out 8
// - drop_o       out  1  one-cycle pulse: an accepted packet was discarded
// - drop_cnt     out  8  saturating count of discarded packets
// BEHAVIOUR
// - Reset:
//   - Clears both FIFOs, output register, starve counter and drop_cnt.
//   - All outputs are 0 while rst=1, including host_rdy.
// - Accept (host side):
//   - Occurs on a rising edge with host_vld & host_rdy.
//   - host_rdy = !full(class host_qos). No write-through: a full FIFO stays not-ready even if it drains that cycle.
// - Source id: pkt_in_src = {HP[2:0],VP[2:0]}, inserted at enqueue.
// - Filter:
//   - Condition: host_tgt == own id, or (pg_en && host_tgt == pg_node).
//   - The packet is accepted (host_rdy ignores the filter), not enqueued, and drop_o pulses on the next cycle.
//   - drop_cnt increments and saturates at 255.
//   - pg_en/pg_node are sampled at accept time only; packets already queued are forwarded unchanged.
// - Output stage:
//   - Single register. Loads when empty or when pkt_in_vld & pkt_in_rdy in the same cycle.
//   - Gives full throughput of 1 packet/cycle.
//   - Fields are stable while pkt_in_vld & !pkt_in_rdy.
// - Latency: a packet accepted on edge k into an empty queue has pkt_in_vld=1 after edge k+1.
// - Arbitration at each output load, evaluated on FIFO heads:
//   - Only one class non-empty -> that class.
//   - Both non-empty -> high class, unless starve_cnt == STARVE_LIM -> low class.
//   - starve_cnt increments on each high grant made while low is non-empty.
//   - starve_cnt clears on a low grant, or whenever low is empty.
// - FIFO pointers: $clog2(DEPTH)+1 bits with a wrap bit.
//   - full = addresses equal and wrap bits differ; empty = pointers equal.
//   - A simultaneous push and pop on a non-empty, non-full FIFO keeps its occupancy.
// - Ordering: FIFO order within each class; no ordering guarantee across classes.
// STRUCTURE
// - Package maze_pkt_pkg:
//   - typedef pkt_t {type[1:0], qos, src[5:0], tgt[5:0], data[7:0]} (23 bits).
//   - node-id helper function.
//   - constants QOS_HI=1, QOS_LO=0.
// - Sub-module inj_fifo:
//   - Synchronous pkt_t FIFO (DEPTH param; push, pop, head, full, empty).
//   - Instantiated twice, once per class.
// - Top level holds the filter, arbiter, starve counter, output register and drop counter.
// TESTING
// - Reset: rst=1 for 3 cycles with host_vld=1 -> host_rdy=0, pkt_in_vld=0, drop_cnt=0; nothing enqueued.
// - Single packet: HP=VP=3, push {type=1,qos=0,tgt=0x09,data=0xA5} on edge k, pkt_in_rdy=1
//   -> pkt_in_vld after edge k+1 with src=0x1B, tgt=0x09, data=0xA5, held for one cycle.
// - Backpressure/full: pkt_in_rdy=0, push 5 low packets with DEPTH=4
//   -> 4 go to the FIFO and 1 to the output register; the 6th push sees host_rdy=0;
//   -> after releasing rdy, data appears in push order, one per cycle.
// - Priority/starvation: 8 high and 2 low queued, rdy=1, STARVE_LIM=4 -> grant order H,H,H,H,L,H,H,H,H,L.
// - Filter: pg_en=1, pg_node=0x12, push tgt=0x12, then tgt=0x1B (self)
//   -> both accepted, two drop_o pulses, drop_cnt=2, no pkt_in_vld.
// - Reset mid-stream: rst asserted with 3 packets queued and pkt_in_vld=1
//   -> next cycle pkt_in_vld=0, both FIFOs empty, starve_cnt=0, drop_cnt=0.

Source files
------------

// File: rtl/maze_pkt_pkg.sv
// Shared packet types and node-id helper for the MAZE local injection stage.
package maze_pkt_pkg;

  localparam logic QOS_HI = 1'b1;
  localparam logic QOS_LO = 1'b0;

  typedef struct packed {
    logic [1:0] typ;
    logic       qos;
    logic [5:0] src;
    logic [5:0] tgt;
    logic [7:0] data;
  } pkt_t;

  function automatic logic [5:0] node_id(input logic [2:0] x, input logic [2:0] y);
    return {x, y};
  endfunction

endpackage

// File: rtl/node_inj_queue_if.sv
// Host-side and node-side packet handshakes of the injection queue.
// master: the queue itself; slave: host plus node port.
interface node_inj_queue_if;

  logic       host_vld;
  logic       host_rdy;
  logic [1:0] host_type;
  logic       host_qos;
  logic [5:0] host_tgt;
  logic [7:0] host_data;

  logic       pkt_in_vld;
  logic       pkt_in_rdy;
  logic [1:0] pkt_in_type;
  logic       pkt_in_qos;
  logic [5:0] pkt_in_src;
  logic [5:0] pkt_in_tgt;
  logic [7:0] pkt_in_data;

  modport master (
    input  host_vld, host_type, host_qos, host_tgt, host_data, pkt_in_rdy,
    output host_rdy, pkt_in_vld, pkt_in_type, pkt_in_qos, pkt_in_src, pkt_in_tgt, pkt_in_data
  );

  modport slave (
    output host_vld, host_type, host_qos, host_tgt, host_data, pkt_in_rdy,
    input  host_rdy, pkt_in_vld, pkt_in_type, pkt_in_qos, pkt_in_src, pkt_in_tgt, pkt_in_data
  );

endinterface

// File: rtl/inj_fifo.sv
// Synchronous packet FIFO for one QoS class; wrap-bit pointers distinguish full from empty.
module inj_fifo
  import maze_pkt_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  pkt_t wdata_i,
  input  logic pop_i,
  output pkt_t head_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  pkt_t        mem_q [DEPTH];
  logic        do_push;
  logic        do_pop;

  always_comb begin
    full_o  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
    empty_o = (wr_q == rd_q);
    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;
    wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
    head_o  = mem_q[rd_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage is never reset; the pointers alone define the contents.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/node_inj_queue.sv
// Local injection stage: filters self/gated-node packets, buffers two QoS classes and feeds the
// node through one registered output slot with strict priority plus an anti-starvation limit.
module node_inj_queue
  import maze_pkt_pkg::*;
#(
  parameter int unsigned HP         = 3,
  parameter int unsigned VP         = 3,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  node_inj_queue_if.master      bus,
  input  logic                  pg_en,
  input  logic [5:0]            pg_node,
  output logic                  drop_o,
  output logic [7:0]            drop_cnt
);

  localparam logic [5:0]  OWN_ID     = node_id(HP[2:0], VP[2:0]);
  localparam int unsigned SW         = $clog2(STARVE_LIM + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

  pkt_t          in_pkt;
  pkt_t          hi_head, lo_head;
  logic          hi_full, lo_full, hi_empty, lo_empty;
  logic          hi_sel, sel_full, host_rdy, accept, filtered;
  logic          push_hi, push_lo, pop_hi, pop_lo;
  logic          out_free, lo_turn;

  pkt_t          out_q, out_d;
  logic          out_vld_q, out_vld_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          drop_q, drop_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;

  inj_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo_hi (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_hi),
    .wdata_i (in_pkt),
    .pop_i   (pop_hi),
    .head_o  (hi_head),
    .full_o  (hi_full),
    .empty_o (hi_empty)
  );

  inj_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo_lo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_lo),
    .wdata_i (in_pkt),
    .pop_i   (pop_lo),
    .head_o  (lo_head),
    .full_o  (lo_full),
    .empty_o (lo_empty)
  );

  always_comb begin
    hi_sel   = (bus.host_qos == QOS_HI);
    sel_full = hi_sel ? hi_full : lo_full;
    // Readiness ignores the filter so dropped packets are still consumed.
    host_rdy = !rst && !sel_full;
    accept   = bus.host_vld && host_rdy;
    filtered = (bus.host_tgt == OWN_ID) || (pg_en && (bus.host_tgt == pg_node));
    in_pkt   = '{typ: bus.host_type, qos: bus.host_qos, src: OWN_ID,
                 tgt: bus.host_tgt, data: bus.host_data};
    push_hi  = accept && !filtered && hi_sel;
    push_lo  = accept && !filtered && (bus.host_qos == QOS_LO);

    out_free = !out_vld_q || bus.pkt_in_rdy;
    lo_turn  = !lo_empty && (hi_empty || (starve_q == STARVE_MAX));
    pop_lo   = out_free && lo_turn;
    pop_hi   = out_free && !hi_empty && !lo_turn;

    out_vld_d = out_vld_q;
    out_d     = out_q;
    if (out_free) begin
      out_vld_d = pop_hi || pop_lo;
      if (pop_hi) begin
        out_d = hi_head;
      end else if (pop_lo) begin
        out_d = lo_head;
      end
    end

    starve_d = starve_q;
    if (lo_empty || pop_lo) begin
      starve_d = '0;
    end else if (pop_hi) begin
      starve_d = starve_q + SW'(1);
    end

    drop_d     = accept && filtered;
    drop_cnt_d = drop_cnt_q;
    if (drop_d && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      starve_q   <= '0;
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      starve_q   <= starve_d;
      drop_q     <= drop_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Outputs are forced low for the whole reset assertion, not just after the first edge.
  assign bus.host_rdy    = host_rdy;
  assign bus.pkt_in_vld  = out_vld_q && !rst;
  assign bus.pkt_in_type = rst ? 2'b0 : out_q.typ;
  assign bus.pkt_in_qos  = rst ? 1'b0 : out_q.qos;
  assign bus.pkt_in_src  = rst ? 6'b0 : out_q.src;
  assign bus.pkt_in_tgt  = rst ? 6'b0 : out_q.tgt;
  assign bus.pkt_in_data = rst ? 8'b0 : out_q.data;
  assign drop_o          = drop_q && !rst;
  assign drop_cnt        = rst ? 8'b0 : drop_cnt_q;

endmodule

// File: tb/tb_node_inj_queue.sv
// Self-checking bench for node_inj_queue: table-driven vectors, a delivery scoreboard and
// hand-written sequences for backpressure, starvation, filtering and reset.
module tb_node_inj_queue;
  import maze_pkt_pkg::*;

  localparam logic [5:0] SELF = 6'h1B;

  logic       clk;
  logic       rst;
  logic       pg_en;
  logic [5:0] pg_node;
  logic       drop_o;
  logic [7:0] drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_drops = 0;

  pkt_t exp_q[$];
  pkt_t sb_exp;
  pkt_t held;
  logic stall_seen = 1'b0;

  node_inj_queue_if bus ();

  node_inj_queue #(
    .HP         (3),
    .VP         (3),
    .DEPTH      (4),
    .STARVE_LIM (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .pg_en    (pg_en),
    .pg_node  (pg_node),
    .drop_o   (drop_o),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic pkt_t mk(input logic [1:0] t, input logic q, input logic [5:0] tg,
                              input logic [7:0] d);
    return '{typ: t, qos: q, src: SELF, tgt: tg, data: d};
  endfunction

  function automatic pkt_t out_pkt();
    return '{typ: bus.pkt_in_type, qos: bus.pkt_in_qos, src: bus.pkt_in_src,
             tgt: bus.pkt_in_tgt, data: bus.pkt_in_data};
  endfunction

  // Scoreboard: every transfer toward the node must match the oldest expected packet.
  always @(negedge clk) begin
    if (!rst && stall_seen) begin
      check("hold_stable", {8'b0, 1'b1, held}, {8'b0, bus.pkt_in_vld, out_pkt()});
    end
    stall_seen = !rst && bus.pkt_in_vld && !bus.pkt_in_rdy;
    held       = out_pkt();
    if (bus.pkt_in_vld && bus.pkt_in_rdy) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: got pkt 0x%0h, expected no packet", out_pkt());
      end else begin
        sb_exp = exp_q.pop_front();
        check("sb_pkt", 32'(out_pkt()), 32'(sb_exp));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] t, input logic q, input logic [5:0] tg,
                       input logic [7:0] d);
    bus.host_vld  = 1'b1;
    bus.host_type = t;
    bus.host_qos  = q;
    bus.host_tgt  = tg;
    bus.host_data = d;
  endtask

  // Drive a packet and hold it until accepted; returns just after the accepting edge.
  task automatic push_wait(input logic [1:0] t, input logic q, input logic [5:0] tg,
                           input logic [7:0] d);
    int n = 0;
    drive(t, q, tg, d);
    @(negedge clk);
    while (!bus.host_rdy && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (!bus.host_rdy) begin
      n_tests++;
      n_fail++;
      $display("FAIL push_timeout: got host_rdy=0 for 40 cycles, expected 1");
    end
    tick();
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      n++;
      @(negedge clk);
    end
    check(name, exp_q.size(), 0);
  endtask

  typedef struct {
    logic [1:0] typ;
    logic       qos;
    logic [5:0] tgt;
    logic [7:0] data;
    logic       pg_en;
    logic [5:0] pg_node;
    logic       drop;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{2'd0, 1'b1, 6'h00, 8'h11, 1'b0, 6'h00, 1'b0};
    vecs[1] = '{2'd2, 1'b0, 6'h3F, 8'h22, 1'b0, 6'h00, 1'b0};
    vecs[2] = '{2'd3, 1'b1, 6'h1B, 8'h33, 1'b0, 6'h00, 1'b1};
    vecs[3] = '{2'd1, 1'b0, 6'h12, 8'h44, 1'b0, 6'h12, 1'b0};
    vecs[4] = '{2'd1, 1'b0, 6'h12, 8'h55, 1'b1, 6'h12, 1'b1};
    vecs[5] = '{2'd2, 1'b1, 6'h13, 8'h66, 1'b1, 6'h12, 1'b0};
    vecs[6] = '{2'd0, 1'b0, 6'h1A, 8'h77, 1'b1, 6'h2D, 1'b0};
    vecs[7] = '{2'd3, 1'b1, 6'h2D, 8'h88, 1'b1, 6'h2D, 1'b1};
    vecs[8] = '{2'd1, 1'b1, 6'h1B, 8'h99, 1'b1, 6'h00, 1'b1};

    // Reset with a valid host packet pending.
    rst = 1'b1;
    pg_en = 1'b0;
    pg_node = 6'h00;
    bus.pkt_in_rdy = 1'b1;
    drive(2'd1, 1'b0, 6'h09, 8'hA5);
    repeat (3) begin
      @(negedge clk);
      check("rst_host_rdy", bus.host_rdy, 0);
      check("rst_pkt_vld", bus.pkt_in_vld, 0);
      check("rst_drop_cnt", drop_cnt, 0);
    end
    tick();
    rst = 1'b0;
    bus.host_vld = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_empty", bus.pkt_in_vld, 0);
    end

    // Single packet latency.
    tick();
    drive(2'd1, 1'b0, 6'h09, 8'hA5);
    exp_q.push_back(mk(2'd1, 1'b0, 6'h09, 8'hA5));
    @(negedge clk);
    check("single_rdy", bus.host_rdy, 1);
    tick();
    bus.host_vld = 1'b0;
    @(negedge clk);
    check("single_lat_k", bus.pkt_in_vld, 0);
    @(negedge clk);
    check("single_lat_k1", bus.pkt_in_vld, 1);
    check("single_src", bus.pkt_in_src, 6'h1B);
    check("single_tgt", bus.pkt_in_tgt, 6'h09);
    check("single_data", bus.pkt_in_data, 8'hA5);
    @(negedge clk);
    check("single_one_cycle", bus.pkt_in_vld, 0);

    // Filter: gated node then self, back to back.
    tick();
    pg_en = 1'b1;
    pg_node = 6'h12;
    drive(2'd0, 1'b0, 6'h12, 8'h01);
    tick();
    drive(2'd0, 1'b1, SELF, 8'h02);
    @(negedge clk);
    check("drop_pg", drop_o, 1);
    check("drop_pg_novld", bus.pkt_in_vld, 0);
    tick();
    bus.host_vld = 1'b0;
    @(negedge clk);
    check("drop_self", drop_o, 1);
    check("drop_self_novld", bus.pkt_in_vld, 0);
    @(negedge clk);
    check("drop_idle", drop_o, 0);
    check("drop_cnt_2", drop_cnt, 2);
    check("drop_end_novld", bus.pkt_in_vld, 0);
    exp_drops = 2;

    // Table-driven vectors, one packet at a time.
    for (int i = 0; i < 9; i++) begin
      tick();
      pg_en = vecs[i].pg_en;
      pg_node = vecs[i].pg_node;
      drive(vecs[i].typ, vecs[i].qos, vecs[i].tgt, vecs[i].data);
      if (!vecs[i].drop) exp_q.push_back(mk(vecs[i].typ, vecs[i].qos, vecs[i].tgt, vecs[i].data));
      else exp_drops++;
      @(negedge clk);
      check("tbl_rdy", bus.host_rdy, 1);
      tick();
      bus.host_vld = 1'b0;
      @(negedge clk);
      check("tbl_drop", drop_o, vecs[i].drop);
    end
    pg_en = 1'b0;
    wait_drain("tbl_drain");
    check("tbl_drop_cnt", drop_cnt, exp_drops);

    // Backpressure: fill output register and low FIFO.
    tick();
    bus.pkt_in_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(mk(2'd2, 1'b0, 6'h05, 8'h10 + 8'(i)));
      push_wait(2'd2, 1'b0, 6'h05, 8'h10 + 8'(i));
    end
    drive(2'd2, 1'b0, 6'h05, 8'h15);
    @(negedge clk);
    check("bp_full_rdy", bus.host_rdy, 0);
    check("bp_out_vld", bus.pkt_in_vld, 1);
    check("bp_out_data", bus.pkt_in_data, 8'h10);
    bus.host_vld = 1'b0;
    bus.host_qos = 1'b1;
    #1;
    check("bp_hi_rdy", bus.host_rdy, 1);
    tick();
    drive(2'd2, 1'b0, 6'h05, 8'h15);
    bus.pkt_in_rdy = 1'b1;
    @(negedge clk);
    check("bp_no_write_through", bus.host_rdy, 0);
    check("bp_drain_vld", bus.pkt_in_vld, 1);
    exp_q.push_back(mk(2'd2, 1'b0, 6'h05, 8'h15));
    tick();
    @(negedge clk);
    check("bp_rdy_again", bus.host_rdy, 1);
    check("bp_drain_vld", bus.pkt_in_vld, 1);
    tick();
    bus.host_vld = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("bp_drain_vld", bus.pkt_in_vld, 1);
    end
    @(negedge clk);
    check("bp_drain_done", bus.pkt_in_vld, 0);
    check("bp_sb_empty", exp_q.size(), 0);

    // Priority and starvation: H0 parks in the output register, H1-H4 and L0-L1 queue.
    tick();
    bus.pkt_in_rdy = 1'b0;
    for (int i = 0; i < 5; i++) push_wait(2'd0, 1'b1, 6'h21, 8'hB0 + 8'(i));
    push_wait(2'd0, 1'b0, 6'h21, 8'hC0);
    push_wait(2'd0, 1'b0, 6'h21, 8'hC1);
    for (int i = 0; i < 5; i++) exp_q.push_back(mk(2'd0, 1'b1, 6'h21, 8'hB0 + 8'(i)));
    exp_q.push_back(mk(2'd0, 1'b0, 6'h21, 8'hC0));
    for (int i = 5; i < 8; i++) exp_q.push_back(mk(2'd0, 1'b1, 6'h21, 8'hB0 + 8'(i)));
    exp_q.push_back(mk(2'd0, 1'b0, 6'h21, 8'hC1));
    bus.pkt_in_rdy = 1'b1;
    for (int i = 5; i < 8; i++) push_wait(2'd0, 1'b1, 6'h21, 8'hB0 + 8'(i));
    bus.host_vld = 1'b0;
    wait_drain("prio_drain");

    // Gating sampled only at accept: a queued packet to the now-gated node is delivered.
    tick();
    bus.pkt_in_rdy = 1'b0;
    exp_q.push_back(mk(2'd3, 1'b0, 6'h12, 8'hD0));
    push_wait(2'd3, 1'b0, 6'h12, 8'hD0);
    bus.host_vld = 1'b0;
    pg_en = 1'b1;
    pg_node = 6'h12;
    @(negedge clk);
    check("pg_hold_nodrop", drop_o, 0);
    tick();
    tick();
    bus.pkt_in_rdy = 1'b1;
    wait_drain("pg_hold_drain");
    pg_en = 1'b0;

    // Drop counter saturation.
    drive(2'd0, 1'b0, SELF, 8'hEE);
    repeat (260) tick();
    bus.host_vld = 1'b0;
    @(negedge clk);
    check("drop_sat", drop_cnt, 8'hFF);
    check("drop_sat_novld", bus.pkt_in_vld, 0);

    // Reset mid-stream with three packets queued behind a held output.
    tick();
    bus.pkt_in_rdy = 1'b0;
    for (int i = 0; i < 4; i++) push_wait(2'd1, 1'b0, 6'h07, 8'hF0 + 8'(i));
    bus.host_vld = 1'b0;
    @(negedge clk);
    check("mrst_pre_vld", bus.pkt_in_vld, 1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("mrst_vld", bus.pkt_in_vld, 0);
    check("mrst_host_rdy", bus.host_rdy, 0);
    check("mrst_drop_cnt", drop_cnt, 0);
    tick();
    rst = 1'b0;
    bus.pkt_in_rdy = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("mrst_fifo_empty", bus.pkt_in_vld, 0);
    end
    check("mrst_drop_cnt_after", drop_cnt, 0);
    check("final_sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
